// File: rtl/bool_tt_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector to NUM_FN parallel
// implementations, captures their tables, and checks them against a golden table and each other.

module bool_tt_lane #(
    parameter int T  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          smp,
    input  logic [IW-1:0] vec,
    input  logic          exp_bit,
    input  logic          fn_bit,
    output logic [T-1:0]  row,
    output logic [T-1:0]  row_nxt,
    output logic          mis
);
    // Table as it will look after this edge's sample; feeds the equivalence compare.
    always_comb begin
        row_nxt      = row;
        row_nxt[vec] = fn_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            mis <= 1'b0;
        end else if (clr) begin
            row <= '0;
            mis <= 1'b0;
        end else if (smp) begin
            row <= row_nxt;
            mis <= mis | (fn_bit ^ exp_bit);
        end
    end
endmodule

module bool_tt_sweeper #(
    parameter int NUM_IN = 3,
    parameter int NUM_FN = 3,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [(1<<NUM_IN)-1:0]       expected,
    input  logic [NUM_FN-1:0]            fn_out,
    output logic [NUM_IN-1:0]            vec,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_FN*(1<<NUM_IN)-1:0] tt,
    output logic [NUM_FN-1:0]            mismatch,
    output logic                         equiv,
    output logic [NUM_IN-1:0]            fail_idx
);
    localparam int T  = 1 << NUM_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state, state_nxt;
    logic   [CW-1:0]             cnt;
    logic   [T-1:0]              exp_q;
    logic                        first_fail;
    logic   [NUM_FN-1:0][T-1:0]  rows, rows_nxt;
    logic   [NUM_FN-1:0]         mis_w;
    logic                        accept, smp, last, exp_bit, any_diff, eq_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        smp       = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    smp  = 1'b1;
                    last = (vec == NUM_IN'(T - 1));
                    if (last) state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign exp_bit  = exp_q[vec];
    assign any_diff = |(fn_out ^ {NUM_FN{exp_bit}});

    genvar k;
    generate
        for (k = 0; k < NUM_FN; k++) begin : g_lane
            bool_tt_lane #(.T(T), .IW(NUM_IN)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (accept),
                .smp     (smp),
                .vec     (vec),
                .exp_bit (exp_bit),
                .fn_bit  (fn_out[k]),
                .row     (rows[k]),
                .row_nxt (rows_nxt[k]),
                .mis     (mis_w[k])
            );
        end
    endgenerate

    assign tt       = rows;
    assign mismatch = mis_w;

    // Compared against the post-sample tables so the final vector is included.
    always_comb begin
        eq_c = 1'b1;
        for (int i = 1; i < NUM_FN; i++)
            if (rows_nxt[i] != rows_nxt[0]) eq_c = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            cnt        <= '0;
            exp_q      <= '0;
            equiv      <= 1'b0;
            fail_idx   <= '0;
            first_fail <= 1'b0;
        end else if (accept) begin
            vec        <= '0;
            cnt        <= CNT_RELOAD;
            exp_q      <= expected;
            equiv      <= 1'b0;
            fail_idx   <= '0;
            first_fail <= 1'b0;
        end else if (state == RUN) begin
            if (!smp) begin
                cnt <= cnt - 1'b1;
            end else begin
                if (any_diff && !first_fail) begin
                    fail_idx   <= vec;
                    first_fail <= 1'b1;
                end
                if (last) begin
                    equiv <= eq_c;
                end else begin
                    vec <= vec + 1'b1;
                    cnt <= CNT_RELOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_bool_tt_sweeper.sv
// Directed bench for bool_tt_sweeper: F = AB + A'C in three copies, SETTLE=1 and SETTLE=3 instances.

module tb_bool_tt_sweeper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start3 = 1'b0;
    logic [7:0]  exp_in = 8'h00, exp3 = 8'h00;
    logic [2:0]  fn_out, fn_out3;
    logic [2:0]  vec, vec3;
    logic        busy, done, busy3, done3;
    logic [23:0] tt, tt3;
    logic [2:0]  mismatch, mismatch3;
    logic        equiv, equiv3;
    logic [2:0]  fail_idx, fail_idx3;
    logic        rnd_mode = 1'b0, fault = 1'b0;
    logic [2:0]  rnd_fn = 3'b000;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    bool_tt_sweeper #(.NUM_IN(3), .NUM_FN(3), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(exp_in), .fn_out(fn_out),
        .vec(vec), .busy(busy), .done(done), .tt(tt), .mismatch(mismatch),
        .equiv(equiv), .fail_idx(fail_idx));

    bool_tt_sweeper #(.NUM_IN(3), .NUM_FN(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .fn_out(fn_out3),
        .vec(vec3), .busy(busy3), .done(done3), .tt(tt3), .mismatch(mismatch3),
        .equiv(equiv3), .fail_idx(fail_idx3));

    function automatic logic f_ok(input logic [2:0] v);
        return (v[2] & v[1]) | (~v[2] & v[0]);
    endfunction

    always_comb begin
        if (rnd_mode) begin
            fn_out = rnd_fn;
        end else begin
            fn_out[0] = f_ok(vec);
            fn_out[1] = fault ? ((vec[2] & vec[1]) | vec[0]) : f_ok(vec);
            fn_out[2] = f_ok(vec);
        end
        fn_out3 = {3{f_ok(vec3)}};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a sweep at the next edge (E0) and follow it to done at E0+8.
    task automatic run_sweep(input logic [7:0] e, input bit hs);
        exp_in = e;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        exp_in = ~e;
        chk("e0_busy", busy, 1);
        chk("e0_done", done, 0);
        chk("e0_vec", vec, 0);
        chk("e0_tt_clr", tt, 0);
        chk("e0_mis_clr", mismatch, 0);
        chk("e0_fidx_clr", fail_idx, 0);
        for (int i = 1; i < 8; i++) begin
            start = (hs && i == 3);
            tick();
            start = 1'b0;
            chk($sformatf("vec_%0d", i), vec, i);
            chk($sformatf("nodone_%0d", i), done, 0);
        end
        tick();
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_vec", vec, 7);
    endtask

    initial begin
        // Reset with start high and random function outputs
        rnd_mode = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_fn = 3'($urandom);
            tick();
            chk("rst_vec", vec, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_tt", tt, 0);
            chk("rst_mis", mismatch, 0);
            chk("rst_equiv", equiv, 0);
            chk("rst_fidx", fail_idx, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("first_start_busy", busy, 1);
        start    = 1'b0;
        rnd_mode = 1'b0;
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("first_sweep_done", done, 1);

        // Golden pass
        run_sweep(8'hCA, 1'b0);
        chk("gold_tt", tt, 24'hCACACA);
        chk("gold_mis", mismatch, 3'b000);
        chk("gold_equiv", equiv, 1);
        chk("gold_fidx", fail_idx, 0);

        // Faulty copy: fn 1 = AB + C
        fault = 1'b1;
        run_sweep(8'hCA, 1'b0);
        chk("fault_mis", mismatch, 3'b010);
        chk("fault_fidx", fail_idx, 5);
        chk("fault_equiv", equiv, 0);
        chk("fault_tt1", tt[15:8], 8'hEA);
        chk("fault_tt", tt, 24'hCAEACA);
        fault = 1'b0;

        // Start during RUN is ignored, then restart from DONE against an all-zero table
        run_sweep(8'hCA, 1'b1);
        chk("hs_equiv", equiv, 1);
        run_sweep(8'h00, 1'b0);
        chk("zero_mis", mismatch, 3'b111);
        chk("zero_fidx", fail_idx, 1);
        chk("zero_tt", tt, 24'hCACACA);
        chk("zero_equiv", equiv, 1);

        // Mid-sweep reset at vec=4
        exp_in = 8'hCA;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_vec4", vec, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", vec, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tt", tt, 0);
        chk("mid_rst_mis", mismatch, 0);
        chk("mid_rst_fidx", fail_idx, 0);
        tick();
        rst_n = 1'b1;
        run_sweep(8'hCA, 1'b0);
        chk("post_rst_tt", tt, 24'hCACACA);
        chk("post_rst_mis", mismatch, 0);
        chk("post_rst_equiv", equiv, 1);

        // SETTLE=3: each vector held three cycles
        exp3   = 8'hCA;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int j = 0; j < 24; j++) begin
            if (j > 0) tick();
            chk($sformatf("s3_vec_%0d", j), vec3, j / 3);
            chk($sformatf("s3_nodone_%0d", j), done3, 0);
        end
        tick();
        chk("s3_done", done3, 1);
        chk("s3_busy", busy3, 0);
        chk("s3_tt", tt3, 24'hCACACA);
        chk("s3_mis", mismatch3, 0);
        chk("s3_equiv", equiv3, 1);
        chk("s3_fidx", fail_idx3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
